data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Load/store sequencer that acts as the initiator on the data-RAM port. Accepts single load/store requests from the processor datapath over a ready/valid handshake and drives the RAM's writeEnable/readEnable/indirect/addr/writeData lines. Waits for the RAM's dataReady on loads and returns the read word with a one-cycle acknowledge. Sits between the control unit/datapath and the data RAM.

## Interface
- ADDR_W, 8, RAM address width
- DATA_W, 8, data word width
- TIMEOUT, 15, max cycles in READ waiting for dataReady (used only with watchdog enabled)

- clk  in  1  system clock; this block runs on rising edge
- clr  in  1  asynchronous, active-high reset
- req  in  1  core request valid
- we  in  1  1 = store, 0 = load; sampled with req
- ind  in  1  indirect load; sampled with req; ignored for stores
- addr  in  ADDR_W  request address
- wdata  in  DATA_W  store data
- ready  out  1  high only in IDLE; request accepted when req && ready at rising edge
- ack  out  1  one-cycle completion pulse
- rdata  out  DATA_W  load result, valid when ack && !we of the completed request; held until next load completes
- err  out  1  completion was a timeout; valid with ack
- ram_writeEnable  out  1  to RAM writeEnable
- ram_readEnable  out  1  to RAM readEnable
- ram_indirect  out  1  to RAM indirect
- ram_addr  out  ADDR_W  to RAM addr
- ram_writeData  out  DATA_W  to RAM writeData
- ram_dataReady  in  1  from RAM dataReady
- ram_readData  in  DATA_W  from RAM readData

## Operation
- States: IDLE, WRITE, READ, DONE.
- IDLE: ready=1. On req: latch we, ind, addr, wdata into request registers; go WRITE if we=1 else READ.
- WRITE: ram_writeEnable=1, ram_readEnable=0 for exactly one cycle; RAM commits at the falling edge inside this cycle. Next state DONE.
- READ: ram_readEnable=1, ram_indirect=latched ind, ram_writeEnable=0. Stay until ram_dataReady=1 sampled at a rising edge; then capture ram_readData into rdata, go DONE.
- DONE: ack=1, all RAM enables 0, ram_indirect=0. Next state IDLE. req ignored in DONE.
- ram_addr, ram_writeData driven from request registers at all times; change only on accept.
- All outputs are registered or decoded from state only; no combinational path from req/ram_dataReady to any output.
- ram_writeEnable and ram_readEnable never high in the same cycle.
- A stale ram_dataReady already high on entry to READ is accepted (RAM re-reads each falling edge while readEnable is held).

## Timing
- Reset (async, immediate): state IDLE, ready=1, ack=0, err=0, rdata=0, all ram_* outputs 0, request registers 0.
- Reset asserted mid-WRITE/READ: enables drop at once; request aborted with no ack; a write may or may not have committed.
- Accept at edge N: store -> WRITE in cycle N+1, ack in cycle N+2. Load with RAM responding in the first READ cycle -> ack in cycle N+2. Each extra wait cycle adds one.
- Throughput: one request per 3 cycles minimum (IDLE, WRITE/READ, DONE).
- ack high exactly one cycle per accepted, non-aborted request.

## Configuration
- DATA_MEM_CTRL_TIMEOUT_EN defined: 4-bit-or-wider wait counter cleared on entry to READ, incremented each READ cycle; on reaching TIMEOUT without dataReady -> DONE with err=1, rdata unchanged. err=0 on all normal completions.
- Undefined: no counter; READ waits indefinitely; err tied 0.

## Structure
- Shared package: state encoding constants (IDLE=0, WRITE=1, READ=2, DONE=3), default widths.
- One sub-module natural: mem_wait_timer (load/clear, count, expired flag), instantiated only under DATA_MEM_CTRL_TIMEOUT_EN.

## Test plan
- Reset then idle: ready=1, ack=0, all ram_* = 0, rdata=0.
- Store addr=0x12 data=0xA5 -> ram_writeEnable high exactly one cycle with ram_addr=0x12, ram_writeData=0xA5; ack at N+2; readback via RAM model gives 0xA5.
- Load addr=0x12, RAM model returns dataReady same cycle -> ack at N+2, rdata=0xA5, err=0.
- Indirect load: mem[0x03]=0x40, mem[0x40]=0x7E, req ind=1 addr=0x03 -> ram_indirect=1 during READ, rdata=0x7E.
- RAM model delays dataReady 3 cycles -> ready stays 0, ack at N+5; with TIMEOUT_EN and TIMEOUT=2, dataReady never asserted -> ack with err=1 after 2 READ cycles, rdata unchanged.
- clr pulse during READ -> enables drop same cycle, no ack, ready=1 after release; next store completes normally.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-RAM load/store sequencer: state encoding,
// default widths and the wait-counter sizing helper.
package data_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 15;

    // Counter must hold TIMEOUT and never be narrower than 4 bits.
    function automatic int wait_cnt_w(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 4) ? 4 : w;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Bundles the core-side request/response signals and the data-RAM port.
// slave = the sequencer; master = core plus RAM environment.
interface data_mem_ctrl_if import data_mem_ctrl_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              req;
    logic              we;
    logic              ind;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              err;

    logic              ram_writeEnable;
    logic              ram_readEnable;
    logic              ram_indirect;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_writeData;
    logic              ram_dataReady;
    logic [DATA_W-1:0] ram_readData;

    modport slave (
        input  req, we, ind, addr, wdata, ram_dataReady, ram_readData,
        output ready, ack, rdata, err,
               ram_writeEnable, ram_readEnable, ram_indirect, ram_addr, ram_writeData
    );

    modport master (
        output req, we, ind, addr, wdata, ram_dataReady, ram_readData,
        input  ready, ack, rdata, err,
               ram_writeEnable, ram_readEnable, ram_indirect, ram_addr, ram_writeData
    );
endinterface

// File: rtl/data_mem_ctrl_mem_wait_timer.sv
// Load wait counter: cleared on READ entry, counts READ cycles; expired marks
// the final READ cycle allowed before the load is abandoned.
module data_mem_ctrl_mem_wait_timer import data_mem_ctrl_pkg::*; #(
    parameter int LIMIT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic clr,
    input  logic load,
    input  logic count,
    output logic expired
);
    localparam int CW = wait_cnt_w(LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (count) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts completed READ cycles, so this cycle is number cnt_q+1.
    assign expired = ((32'(cnt_q) + 32'd1) >= 32'(LIMIT));

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store sequencer driving the data-RAM port; one request per >=3 cycles.
// Optional load watchdog enabled by defining DATA_MEM_CTRL_TIMEOUT_EN.
module data_mem_ctrl import data_mem_ctrl_pkg::*; #(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             clr,
    data_mem_ctrl_if.slave   bus
);
    state_e            state_q, state_d;
    logic              ind_q, ind_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              wen_q, wen_d;
    logic              ren_q, ren_d;
    logic              rind_q, rind_d;
    logic              timed_out;

`ifdef DATA_MEM_CTRL_TIMEOUT_EN
    logic tmr_load, tmr_count, tmr_expired;

    assign tmr_load  = (state_q != ST_READ) && (state_d == ST_READ);
    assign tmr_count = (state_q == ST_READ);

    data_mem_ctrl_mem_wait_timer #(.LIMIT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .clr     (clr),
        .load    (tmr_load),
        .count   (tmr_count),
        .expired (tmr_expired)
    );

    assign timed_out = tmr_expired;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign timed_out      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ind_d   = ind_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    ind_d   = bus.ind & ~bus.we;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    state_d = bus.we ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: state_d = ST_DONE;
            ST_READ: begin
                // A response arriving in the last permitted cycle still wins.
                if (bus.ram_dataReady) begin
                    rdata_d = bus.ram_readData;
                    state_d = ST_DONE;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
        ack_d   = (state_d == ST_DONE);
        wen_d   = (state_d == ST_WRITE);
        ren_d   = (state_d == ST_READ);
        rind_d  = (state_d == ST_READ) && ind_d;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            ind_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b1;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
            rind_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ind_q   <= ind_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            wen_q   <= wen_d;
            ren_q   <= ren_d;
            rind_q  <= rind_d;
        end
    end

    assign bus.ready           = ready_q;
    assign bus.ack             = ack_q;
    assign bus.rdata           = rdata_q;
    assign bus.err             = err_q;
    assign bus.ram_writeEnable = wen_q;
    assign bus.ram_readEnable  = ren_q;
    assign bus.ram_indirect    = rind_q;
    assign bus.ram_addr        = addr_q;
    assign bus.ram_writeData   = wdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed plus randomized load/store traffic against a RAM model, checked
// against a shadow memory that predicts read values, latency and err.
module tb_data_mem_ctrl;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 4;
`ifdef DATA_MEM_CTRL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    data_mem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    data_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    logic [7:0] ram     [256];
    logic [7:0] ref_mem [256];
    int         rd_delay = 0;
    int         rd_cnt   = 0;
    int         n_pass   = 0;
    int         n_chk    = 0;
    logic [7:0] exp_rdata;

    // RAM: commits/re-reads at the falling edge; dataReady after rd_delay cycles.
    always @(negedge clk) begin
        if (bus.ram_writeEnable) ram[bus.ram_addr] = bus.ram_writeData;
        if (bus.ram_readEnable) begin
            if (rd_cnt >= rd_delay) begin
                bus.ram_dataReady = 1'b1;
                bus.ram_readData  = bus.ram_indirect ? ram[ram[bus.ram_addr]] : ram[bus.ram_addr];
            end else begin
                bus.ram_dataReady = 1'b0;
            end
            rd_cnt++;
        end else begin
            bus.ram_dataReady = 1'b0;
            rd_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issue one request from IDLE (caller sits 1 time unit after a rising edge).
    task automatic run_req(input string tag, input bit w, input bit i,
                           input logic [7:0] a, input logic [7:0] d, input int delay);
        int   lat, we_cycles, exp_lat;
        bit   exp_err, got_ack, overlap, ind_ok, hold_ok, busy_ok;
        logic [7:0] ia;
        if (w) begin
            ref_mem[a] = d;
            exp_err    = 1'b0;
            exp_lat    = 2;
        end else begin
            exp_err = TMO_EN && (delay >= TO);
            exp_lat = exp_err ? TO + 1 : delay + 2;
            if (!exp_err) begin
                ia        = ref_mem[a];
                exp_rdata = i ? ref_mem[ia] : ref_mem[a];
            end
        end
        rd_delay = delay;
        chk({tag, "_ready_pre"}, 32'(bus.ready), 32'd1);
        bus.req = 1'b1; bus.we = w; bus.ind = i; bus.addr = a; bus.wdata = d;
        @(posedge clk); #1;
        lat = 1; got_ack = 0; we_cycles = 0;
        overlap = 0; ind_ok = 1; hold_ok = 1; busy_ok = 1;
        while (!got_ack && lat < 40) begin
            if (bus.ack === 1'b1) begin
                got_ack = 1;
                bus.req = 1'b0;
            end else begin
                // Garbage on the request lines while busy must be ignored.
                bus.req = 1'($urandom_range(0, 1)); bus.we = 1'($urandom_range(0, 1));
                bus.ind = 1'($urandom_range(0, 1));
                bus.addr = 8'($urandom); bus.wdata = 8'($urandom);
                if (bus.ram_writeEnable === 1'b1) we_cycles++;
                if (bus.ram_writeEnable && bus.ram_readEnable) overlap = 1;
                if (bus.ram_readEnable && (bus.ram_indirect !== i)) ind_ok = 0;
                if (!bus.ram_readEnable && (bus.ram_indirect !== 1'b0)) ind_ok = 0;
                if (bus.ram_addr !== a || bus.ram_writeData !== d) hold_ok = 0;
                if (bus.ready !== 1'b0) busy_ok = 0;
                @(posedge clk); #1;
                lat++;
            end
        end
        chk({tag, "_ack_seen"}, 32'(got_ack), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        chk({tag, "_rdata"}, 32'(bus.rdata), 32'(exp_rdata));
        chk({tag, "_we_cycles"}, 32'(we_cycles), w ? 32'd1 : 32'd0);
        chk({tag, "_no_overlap"}, 32'(overlap), 32'd0);
        chk({tag, "_indirect"}, 32'(ind_ok), 32'd1);
        chk({tag, "_addr_data_held"}, 32'(hold_ok), 32'd1);
        chk({tag, "_busy_not_ready"}, 32'(busy_ok && !bus.ready && !bus.ram_readEnable && !bus.ram_writeEnable), 32'd1);
        @(posedge clk); #1;
        chk({tag, "_ack_one_cycle"}, 32'(bus.ack), 32'd0);
        chk({tag, "_ready_post"}, 32'(bus.ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int acks;
        clr = 1'b1;
        bus.req = 1'b0; bus.we = 1'b0; bus.ind = 1'b0; bus.addr = '0; bus.wdata = '0;
        for (int k = 0; k < 256; k++) begin
            ram[k]     = 8'($urandom);
            ref_mem[k] = ram[k];
        end
        ram[8'h03] = 8'h40; ref_mem[8'h03] = 8'h40;
        ram[8'h40] = 8'h7E; ref_mem[8'h40] = 8'h7E;
        exp_rdata = 8'h00;
        #12;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        chk("rst_ram_ctl", {29'd0, bus.ram_writeEnable, bus.ram_readEnable, bus.ram_indirect}, 32'd0);
        chk("rst_ram_bus", {16'd0, bus.ram_addr, bus.ram_writeData}, 32'd0);
        @(negedge clk) clr = 1'b0;
        @(posedge clk); #1;
        chk("idle_ready", 32'(bus.ready), 32'd1);

        run_req("store12", 1'b1, 1'b0, 8'h12, 8'hA5, 0);
        chk("ram_commit12", 32'(ram[8'h12]), 32'hA5);
        run_req("load12", 1'b0, 1'b0, 8'h12, 8'h00, 0);
        chk("load12_value", 32'(bus.rdata), 32'hA5);
        run_req("ind03", 1'b0, 1'b1, 8'h03, 8'h00, 0);
        chk("ind03_value", 32'(bus.rdata), 32'h7E);
        run_req("delay3", 1'b0, 1'b0, 8'h40, 8'h00, 3);
        if (TMO_EN) run_req("timeout", 1'b0, 1'b0, 8'h12, 8'h00, 1000);

        for (int n = 0; n < 30; n++) begin
            run_req($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 5));
        end

        // Abort a load mid-READ with an asynchronous reset pulse.
        rd_delay = 1000;
        bus.req = 1'b1; bus.we = 1'b0; bus.ind = 1'b1; bus.addr = 8'h03;
        @(posedge clk); #1;
        bus.req = 1'b0;
        @(posedge clk); #2;
        chk("pre_clr_reading", 32'(bus.ram_readEnable), 32'd1);
        clr = 1'b1;
        #1;
        chk("clr_ren_drop", 32'(bus.ram_readEnable), 32'd0);
        chk("clr_ind_drop", 32'(bus.ram_indirect), 32'd0);
        chk("clr_ready", 32'(bus.ready), 32'd1);
        chk("clr_addr", 32'(bus.ram_addr), 32'd0);
        chk("clr_rdata", 32'(bus.rdata), 32'd0);
        exp_rdata = 8'h00;
        @(negedge clk) clr = 1'b0;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.ack === 1'b1) acks++;
        end
        chk("clr_no_ack", 32'(acks), 32'd0);
        run_req("post_clr_store", 1'b1, 1'b0, 8'h55, 8'h3C, 0);
        run_req("post_clr_load", 1'b0, 1'b0, 8'h55, 8'h00, 1);
        chk("post_clr_value", 32'(bus.rdata), 32'h3C);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
